sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Single-clock streaming FIFO controller that owns a 16×8 one-write/one-read SRAM macro and wraps it in valid/ready handshakes. It sits directly upstream of the macro: it drives the write port, issues read requests and captures read data. A 2-entry output buffer gives show-ahead output at one word per cycle. Producers and consumers never see SRAM latency.

## Interface
- DATA_WIDTH, 8, word width; must match the macro.
- ADDR_WIDTH, 4, SRAM address width; DEPTH = 1<<ADDR_WIDTH = 16.
- clk  in  1  single clock; also drives both SRAM clocks (clk0 = clk1 = clk).
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  producer has a word.
- s_ready  out  1  controller accepts the word this cycle.
- s_data  in  DATA_WIDTH  producer word.
- m_valid  out  1  m_data holds the oldest word.
- m_ready  in  1  consumer takes the word this cycle.
- m_data  out  DATA_WIDTH  head of the FIFO.
- count  out  ADDR_WIDTH+1  total occupancy: SRAM + in-flight + output buffer, range 0..18.
- sram_csb0  out  1  write chip select, active-low.
- sram_addr0  out  ADDR_WIDTH  write address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_csb1  out  1  read chip select, active-low.
- sram_addr1  out  ADDR_WIDTH  read address.
- sram_dout1  in  DATA_WIDTH  read data from the macro.

## Operation
- State: wptr and rptr (ADDR_WIDTH, wrap mod DEPTH), sram_cnt (0..16), inflight (1 bit), obuf (2 entries, obuf_cnt 0..2).
- Write:
  - s_ready = rst_n && (sram_cnt < DEPTH).
  - On accept (s_valid && s_ready), drive sram_csb0=0, sram_addr0=wptr and sram_din0=s_data combinationally in the same cycle.
  - wptr increments at the following posedge.
- Read issue:
  - Condition: sram_cnt != 0 and (obuf_cnt + inflight − pop) < 2, where pop = m_valid && m_ready.
  - On issue, drive sram_csb1=0 and sram_addr1=rptr; rptr increments and inflight is set at the posedge.
  - The issue path is combinational from m_ready.
- Capture:
  - When inflight=1, sram_dout1 is written into obuf at the next posedge and inflight clears, unless another read is issued in that cycle.
  - sram_dout1 is ignored whenever inflight=0; the macro drives X between reads.
- sram_cnt update: +1 on accept and −1 on issue. Both in one cycle leave it unchanged.
- Read and write never address the same location in one cycle. wptr==rptr only when sram_cnt is 0 (no read) or 16 (no write).
- The obuf is FIFO-ordered: m_data = oldest entry, m_valid = (obuf_cnt != 0). Push and pop in the same cycle are legal.
- Full: s_ready=0 at sram_cnt=16. count peaks at 18 when the obuf is also full.
- Empty: sram_csb1 stays 1 and m_valid stays 0.
- Reset:
  - rst_n low clears wptr, rptr, sram_cnt, inflight and obuf.
  - Combinationally forces s_ready=0, sram_csb0=1 and sram_csb1=1.
  - Outputs during reset: m_valid=0, count=0, m_data=0, addresses=0.
  - A read in flight when reset asserts is discarded. SRAM contents are not cleared and are never reused, because the pointers restart at 0.

## Timing
- Write-to-output latency (empty FIFO):
  - Cycle 0: accept.
  - Cycle 1: read issue.
  - End of cycle 2: capture.
  - Cycle 3: m_valid=1.
- Steady-state throughput is 1 word/cycle in and 1 word/cycle out, with no bubbles while m_ready=1.
- The macro registers its inputs at posedge, writes at negedge, and presents read data at negedge + 3 ns, going X 1 ns after the next posedge.
- Capture at posedge is therefore valid. Simulation clock period must be ≥ 8 ns.
- A word written in cycle N may be read from cycle N+1 onward.

## Structure
- Package sram_fifo_pkg holds the constants DATA_WIDTH, ADDR_WIDTH, DEPTH and OBUF_DEPTH=2, plus a typedef for the word and one for the address.
- Sub-module fifo_obuf: 2-entry show-ahead output buffer with push/pop, data and occupancy.
- The top level holds the pointers, counters, issue logic and SRAM port drive.

## Test plan
- Reset, then write 0xA5 → same cycle sram_csb0=0, addr0=0, din0=0xA5; 3 cycles later m_valid=1, m_data=0xA5, count=1.
- m_ready=0, offer 0x00..0x13 → 18 words accepted (count=18), then s_ready=0. Set m_ready=1 → 0x00..0x11 emerge in order, one per cycle; s_ready rises the cycle after the first read issue.
- s_valid=m_ready=1 for 40 words → output continuous after the initial latency; pointers wrap twice; order preserved; addr0 never equals addr1 while both csb are low.
- m_ready toggles 1,0,1,0 over 30 words, s_valid random → no loss or duplication; count matches the scoreboard every cycle.
- 5 words stored and a read in flight, then assert rst_n low mid-cycle → m_valid, count, s_ready = 0 and both csb = 1 immediately. After release, write 0x3C → first output is 0x3C.
- Idle 20 cycles after reset with s_valid=0 → sram_csb1=1 and m_valid=0 throughout; X on sram_dout1 is never captured.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared widths and types for the SRAM-backed streaming FIFO.
package sram_fifo_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int OBUF_DEPTH = 2;
   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [ADDR_WIDTH:0] cnt_t;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: producer/consumer stream handshakes plus occupancy.
interface sram_fifo_ctrl_if;
   import sram_fifo_pkg::*;
   logic s_valid;
   logic s_ready;
   word_t s_data;
   logic m_valid;
   logic m_ready;
   word_t m_data;
   cnt_t count;
   modport slave(input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, count);
   modport master(output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, count);
endinterface

// File: rtl/sram_fifo_ctrl_obuf.sv
// fifo_obuf: 2-entry show-ahead output buffer; dout is always the oldest entry.
module fifo_obuf import sram_fifo_pkg::*; (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  word_t din,
   output word_t dout,
   output logic [1:0] cnt
);
   word_t mem [OBUF_DEPTH];
   logic head, tail;
   assign dout = mem[head];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem <= '{default: '0};
         head <= 1'b0;
         tail <= 1'b0;
         cnt <= '0;
      end else begin
         if (push) mem[tail] <= din;
         tail <= tail ^ push;
         head <= head ^ pop;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO around a 1W/1R SRAM macro with a 2-entry
// show-ahead output buffer hiding the one-cycle read latency.
module sram_fifo_ctrl import sram_fifo_pkg::*; (
   input  logic clk,
   input  logic rst_n,
   sram_fifo_ctrl_if.slave bus,
   output logic sram_csb0,
   output addr_t sram_addr0,
   output word_t sram_din0,
   output logic sram_csb1,
   output addr_t sram_addr1,
   input  word_t sram_dout1
);
   addr_t wptr, rptr;
   cnt_t sram_cnt;
   logic inflight, accept, issue, pop;
   logic [1:0] obuf_cnt;
   assign bus.s_ready = rst_n && (sram_cnt < cnt_t'(DEPTH));
   assign accept = bus.s_valid && bus.s_ready;
   assign pop = bus.m_valid && bus.m_ready;
   // issue only while the buffer has room for everything already on its way
   assign issue = rst_n && (sram_cnt != '0) &&
                  ({1'b0, obuf_cnt} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
   assign sram_csb0 = !accept;
   assign sram_addr0 = wptr;
   assign sram_din0 = bus.s_data;
   assign sram_csb1 = !issue;
   assign sram_addr1 = rptr;
   assign bus.m_valid = obuf_cnt != 2'd0;
   assign bus.count = sram_cnt + cnt_t'(inflight) + cnt_t'(obuf_cnt);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         sram_cnt <= '0;
         inflight <= 1'b0;
      end else begin
         wptr <= wptr + addr_t'(accept);
         rptr <= rptr + addr_t'(issue);
         sram_cnt <= sram_cnt + cnt_t'(accept) - cnt_t'(issue);
         inflight <= issue;
      end
   fifo_obuf u_obuf (
      .clk(clk),
      .rst_n(rst_n),
      .push(inflight),
      .pop(pop),
      .din(sram_dout1),
      .dout(bus.m_data),
      .cnt(obuf_cnt)
   );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: scoreboard bench with a timed behavioural model of the SRAM macro.
module tb_sram_fifo_ctrl;
   import sram_fifo_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sram_csb0, sram_csb1;
   addr_t sram_addr0, sram_addr1;
   word_t sram_din0, sram_dout1;
   int total = 0;
   int bad = 0;
   word_t exp_q[$];
   int mcount = 0;
   addr_t mwptr = '0;
   sram_fifo_ctrl_if bus();
   sram_fifo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
      .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
   );
   always #5 clk = ~clk;
   // macro model: inputs registered at posedge, write at negedge, data at negedge+3, X 1 ns after posedge
   word_t mem [DEPTH];
   logic wr_pend = 1'b0, rd_pend = 1'b0;
   addr_t wa, ra;
   word_t wd;
   always @(posedge clk) begin
      wr_pend <= !sram_csb0;
      wa <= sram_addr0;
      wd <= sram_din0;
      rd_pend <= !sram_csb1;
      ra <= sram_addr1;
   end
   always @(posedge clk) begin
      #1 sram_dout1 = 'x;
   end
   always @(negedge clk) begin
      if (wr_pend) mem[wa] = wd;
      if (rd_pend) #3 sram_dout1 = mem[ra];
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         mcount = 0;
         mwptr = '0;
      end else begin
         chk("count", 32'(bus.count), 32'(mcount));
         if (!sram_csb0 && !sram_csb1) chk("addr_clash", 32'(sram_addr0 != sram_addr1), 32'd1);
         if (bus.s_valid && bus.s_ready) begin
            chk("wr_addr0", 32'(sram_addr0), 32'(mwptr));
            chk("wr_din0", 32'(sram_din0), 32'(bus.s_data));
            chk("wr_csb0", 32'(sram_csb0), 32'd0);
            exp_q.push_back(bus.s_data);
            mwptr++;
            mcount++;
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) chk("underflow", 32'(bus.m_data), 32'hFFFF_FFFF);
            else chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
            mcount--;
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input word_t d);
      bit ok = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data = d;
      for (int k = 0; k < 300 && !ok; k++) begin
         #1 ok = bus.s_ready;
         step();
      end
      bus.s_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask
   task automatic drain();
      bus.m_ready = 1'b1;
      for (int k = 0; k < 100 && (exp_q.size() != 0 || bus.count != '0); k++) step();
      chk("drain_q", 32'(exp_q.size()), 32'd0);
      chk("drain_count", 32'(bus.count), 32'd0);
   endtask
   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.m_ready = 1'b0;
      #3;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_csb1", 32'(sram_csb1), 32'd1);
      step();
      step();
      rst_n = 1'b1;
      step();
      // single word latency
      bus.s_valid = 1'b1;
      bus.s_data = 8'hA5;
      #1;
      chk("a5_csb0", 32'(sram_csb0), 32'd0);
      chk("a5_addr0", 32'(sram_addr0), 32'd0);
      chk("a5_din0", 32'(sram_din0), 32'hA5);
      step();
      bus.s_valid = 1'b0;
      chk("lat_c1", 32'(bus.m_valid), 32'd0);
      step();
      chk("lat_c2", 32'(bus.m_valid), 32'd0);
      step();
      chk("lat_c3_valid", 32'(bus.m_valid), 32'd1);
      chk("lat_c3_data", 32'(bus.m_data), 32'hA5);
      chk("lat_c3_count", 32'(bus.count), 32'd1);
      drain();
      // fill to 18 with consumer stalled
      bus.m_ready = 1'b0;
      for (int i = 0; i < 18; i++) send(word_t'(i));
      step();
      step();
      chk("full_count", 32'(bus.count), 32'd18);
      bus.s_valid = 1'b1;
      bus.s_data = 8'h12;
      #1;
      chk("full_s_ready", 32'(bus.s_ready), 32'd0);
      bus.m_ready = 1'b1;
      #1;
      chk("full_s_ready_pop", 32'(bus.s_ready), 32'd0);
      step();
      chk("s_ready_rise", 32'(bus.s_ready), 32'd1);
      bus.s_valid = 1'b0;
      for (int i = 1; i < 18; i++) begin
         chk("drain_contig", 32'(bus.m_valid), 32'd1);
         step();
      end
      drain();
      // streaming, 40 words with no bubbles
      fork
         for (int i = 0; i < 40; i++) send(word_t'(8'h40 + i));
         begin
            step();
            step();
            step();
            for (int i = 0; i < 40; i++) begin
               chk("stream_valid", 32'(bus.m_valid), 32'd1);
               step();
            end
         end
      join
      drain();
      // toggling consumer, irregular producer
      fork
         for (int i = 0; i < 30; i++) begin
            send(word_t'(8'h80 + i));
            repeat (i % 3 == 1 ? 1 : 0) step();
         end
         for (int k = 0; k < 200 && (k < 30 || exp_q.size() != 0); k++) begin
            bus.m_ready = k[0] ? 1'b0 : 1'b1;
            step();
         end
      join
      drain();
      // reset with a read in flight
      bus.m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(word_t'(8'h10 + i));
      step();
      step();
      bus.m_ready = 1'b1;
      @(posedge clk);
      bus.m_ready = 1'b0;
      #3 rst_n = 1'b0;
      bus.s_valid = 1'b1;
      #1;
      chk("mr_m_valid", 32'(bus.m_valid), 32'd0);
      chk("mr_count", 32'(bus.count), 32'd0);
      chk("mr_s_ready", 32'(bus.s_ready), 32'd0);
      chk("mr_csb0", 32'(sram_csb0), 32'd1);
      chk("mr_csb1", 32'(sram_csb1), 32'd1);
      chk("mr_m_data", 32'(bus.m_data), 32'd0);
      chk("mr_addr0", 32'(sram_addr0), 32'd0);
      chk("mr_addr1", 32'(sram_addr1), 32'd0);
      bus.s_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      send(8'h3C);
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 10 && !seen; k++) begin
            seen = bus.m_valid;
            if (!seen) step();
         end
         chk("post_rst_valid", 32'(seen), 32'd1);
         chk("post_rst_data", 32'(bus.m_data), 32'h3C);
      end
      drain();
      // idle after reset
      bus.m_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         chk("idle_csb1", 32'(sram_csb1), 32'd1);
         chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
